// File: rtl/dshot_pkg.sv
// dshot_pkg: shared DShot frame constants, decoder FSM state type, checksum
// and throttle-to-speed mapping used by dshot_decoder.
package dshot_pkg;

  localparam int FRAME_BITS   = 16;
  localparam int CMD_MAX      = 47;
  localparam int THROTTLE_MIN = 48;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HIGH,
    ST_LOW,
    ST_CHECK
  } state_t;

  // DShot checksum: XOR of the three nibbles of {throttle, telemetry}.
  function automatic logic [3:0] dshot_crc(input logic [11:0] v);
    return v[3:0] ^ v[7:4] ^ v[11:8];
  endfunction

  // Throttle 0 stops the motor, command codes leave the speed untouched.
  function automatic logic [7:0] map_speed(input logic [10:0] thr, input logic [7:0] cur);
    logic [10:0] off;
    off = thr - 11'(THROTTLE_MIN);
    if (thr == 11'd0) return 8'd0;
    else if (thr <= 11'(CMD_MAX)) return cur;
    else return off[10:3];
  endfunction

endpackage

// File: rtl/dshot_sync.sv
// dshot_sync: two-flop synchronizer bringing the asynchronous DShot line
// into the clk domain; both flops reset to 0.
module dshot_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/dshot_decoder.sv
// dshot_decoder: measures DShot pulse widths, assembles 16-bit frames and
// publishes throttle/telemetry/speed. Define DSHOT_FAILSAFE_EN for the watchdog.
module dshot_decoder
  import dshot_pkg::*;
#(
  parameter int BIT_CYCLES  = 107,
  parameter int HIGH_THRESH = 60,
  parameter int MIN_HIGH    = 8,
  parameter int GAP_CYCLES  = 214
`ifdef DSHOT_FAILSAFE_EN
  ,
  parameter int FAILSAFE_CYCLES = 16000
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dshot_in,
  output logic [10:0] throttle,
  output logic        telem_req,
  output logic [7:0]  speed,
  output logic        frame_valid,
  output logic        crc_err,
  output logic        frame_err,
  output logic        failsafe
);

  localparam logic [15:0] BIT_LIM  = 16'(BIT_CYCLES);
  localparam logic [15:0] HI_LIM   = 16'(HIGH_THRESH);
  localparam logic [15:0] MIN_LIM  = 16'(MIN_HIGH);
  localparam logic [15:0] GAP_LIM  = 16'(GAP_CYCLES);
  localparam logic [4:0]  LAST_BIT = 5'(FRAME_BITS);

  state_t      state;
  logic        line;
  logic        line_d;
  logic        rise;
  logic        fall;
  logic [15:0] cnt;
  logic [15:0] cnt_inc;
  logic [4:0]  bit_count;
  logic [15:0] shreg;
  logic        crc_ok;

`ifdef DSHOT_FAILSAFE_EN
  localparam int             WD_W    = $clog2(FAILSAFE_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(FAILSAFE_CYCLES - 1);
  logic [WD_W-1:0] wd_cnt;
`else
  assign failsafe = 1'b0;
`endif

  dshot_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (dshot_in),
    .q     (line)
  );

  assign rise    = line & ~line_d;
  assign fall    = ~line & line_d;
  // cnt_inc is the length of the current phase including the present cycle.
  assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  assign crc_ok  = (dshot_crc(shreg[15:4]) == shreg[3:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      line_d      <= 1'b0;
      cnt         <= '0;
      bit_count   <= '0;
      shreg       <= '0;
      throttle    <= '0;
      telem_req   <= 1'b0;
      speed       <= '0;
      frame_valid <= 1'b0;
      crc_err     <= 1'b0;
      frame_err   <= 1'b0;
`ifdef DSHOT_FAILSAFE_EN
      wd_cnt      <= '0;
      failsafe    <= 1'b1;
`endif
    end else begin
      line_d      <= line;
      frame_valid <= 1'b0;
      crc_err     <= 1'b0;
      frame_err   <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (rise) begin
            state     <= ST_HIGH;
            cnt       <= '0;
            bit_count <= '0;
          end
        end

        ST_HIGH: begin
          if (fall) begin
            if (cnt_inc < MIN_LIM) begin
              frame_err <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              shreg     <= {shreg[14:0], cnt_inc >= HI_LIM};
              bit_count <= bit_count + 5'd1;
              cnt       <= '0;
              state     <= ST_LOW;
            end
          end else if (cnt_inc > BIT_LIM) begin
            frame_err <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            cnt <= cnt_inc;
          end
        end

        ST_LOW: begin
          if (bit_count == LAST_BIT) begin
            state <= ST_CHECK;
          end else if (rise) begin
            cnt   <= '0;
            state <= ST_HIGH;
          end else if (cnt_inc >= GAP_LIM) begin
            frame_err <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            cnt <= cnt_inc;
          end
        end

        ST_CHECK: begin
          state <= ST_IDLE;
          if (crc_ok) begin
            throttle    <= shreg[15:5];
            telem_req   <= shreg[4];
            speed       <= map_speed(shreg[15:5], speed);
            frame_valid <= 1'b1;
          end else begin
            crc_err <= 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase

`ifdef DSHOT_FAILSAFE_EN
      // A good frame restarts the watchdog; expiry forces the motor to stop.
      if (state == ST_CHECK && crc_ok) begin
        wd_cnt   <= '0;
        failsafe <= 1'b0;
      end else if (!failsafe) begin
        if (wd_cnt == WD_LAST) begin
          failsafe <= 1'b1;
          speed    <= 8'd0;
        end else begin
          wd_cnt <= wd_cnt + WD_W'(1);
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_dshot_decoder.sv
// tb_dshot_decoder: drives directed and randomized DShot frames into
// dshot_decoder and compares against a frame-level reference model.
`timescale 1ns/1ps
module tb_dshot_decoder;

  localparam int BIT_CYCLES = 107;
  localparam int HI_ONE     = 80;
  localparam int HI_ZERO    = 40;
`ifdef DSHOT_FAILSAFE_EN
  localparam logic FS_AT_RESET = 1'b1;
`else
  localparam logic FS_AT_RESET = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dshot_in;
  logic [10:0] throttle;
  logic        telem_req;
  logic [7:0]  speed;
  logic        frame_valid;
  logic        crc_err;
  logic        frame_err;
  logic        failsafe;

  always #5 clk = ~clk;

  dshot_decoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dshot_in    (dshot_in),
    .throttle    (throttle),
    .telem_req   (telem_req),
    .speed       (speed),
    .frame_valid (frame_valid),
    .crc_err     (crc_err),
    .frame_err   (frame_err),
    .failsafe    (failsafe)
  );

  int vectors     = 0;
  int miscompares = 0;
  int n_valid     = 0;
  int n_crc       = 0;
  int n_ferr      = 0;
  int n_overlap   = 0;
  int bad_streak  = 0;

  // Reference model state: what the outputs should hold after each event.
  logic [10:0] exp_throttle;
  logic        exp_telem;
  logic [7:0]  exp_speed;
  logic        exp_failsafe;

  // Pulse monitor: counts high cycles of each pulse output, flags overlaps.
  always @(negedge clk) begin
    if (frame_valid) n_valid++;
    if (crc_err)     n_crc++;
    if (frame_err)   n_ferr++;
    if (int'(frame_valid) + int'(crc_err) + int'(frame_err) > 1) n_overlap++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic logic [3:0] modelCrc(input logic [15:0] w);
    int v;
    v = int'(w >> 4);
    return 4'((v ^ (v >> 4) ^ (v >> 8)) & 15);
  endfunction

  function automatic logic [7:0] modelSpeed(input int thr, input logic [7:0] cur);
    if (thr == 0) return 8'd0;
    if (thr < 48) return cur;
    return 8'((thr - 48) / 8);
  endfunction

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sendBits(input logic [15:0] word, input int nbits);
    for (int i = 15; i > 15 - nbits; i--) begin
      int hi;
      hi = word[i] ? HI_ONE : HI_ZERO;
      dshot_in = 1'b1;
      waitCycles(hi);
      dshot_in = 1'b0;
      waitCycles(BIT_CYCLES - hi);
    end
  endtask

  task automatic checkAll(input string tag, input int v0, input int c0, input int f0,
                          input int ev, input int ec, input int ef);
    checkOutput({tag, " valid"},     32'(n_valid - v0), 32'(ev));
    checkOutput({tag, " crc_err"},   32'(n_crc - c0),   32'(ec));
    checkOutput({tag, " frame_err"}, 32'(n_ferr - f0),  32'(ef));
    checkOutput({tag, " throttle"},  32'(throttle),     32'(exp_throttle));
    checkOutput({tag, " telem"},     32'(telem_req),    32'(exp_telem));
    checkOutput({tag, " speed"},     32'(speed),        32'(exp_speed));
    checkOutput({tag, " failsafe"},  32'(failsafe),     32'(exp_failsafe));
  endtask

  task automatic applyStimulus(input string tag, input logic [15:0] word);
    int v0, c0, f0;
    bit good;
    v0 = n_valid;
    c0 = n_crc;
    f0 = n_ferr;
    sendBits(word, 16);
    waitCycles(40);
    good = (modelCrc(word) == word[3:0]);
    if (good) begin
      exp_speed    = modelSpeed(int'(word[15:5]), exp_speed);
      exp_throttle = word[15:5];
      exp_telem    = word[4];
      exp_failsafe = 1'b0;
    end
    checkAll(tag, v0, c0, f0, good ? 1 : 0, good ? 0 : 1, 0);
  endtask

  task automatic doReset();
    dshot_in = 1'b0;
    rst_n    = 1'b0;
    waitCycles(5);
    exp_throttle = '0;
    exp_telem    = 1'b0;
    exp_speed    = '0;
    exp_failsafe = FS_AT_RESET;
    rst_n = 1'b1;
  endtask

  initial begin
    int v0, c0, f0;
    dshot_in = 1'b0;
    rst_n    = 1'b0;
    doReset();
    v0 = n_valid; c0 = n_crc; f0 = n_ferr;
    waitCycles(10);
    checkAll("reset", v0, c0, f0, 0, 0, 0);

    applyStimulus("f830B", 16'h830B);
    applyStimulus("fFFFF", 16'hFFFF);
    applyStimulus("f830A_badcrc", 16'h830A);

    v0 = n_valid; c0 = n_crc; f0 = n_ferr;
    sendBits(16'h830B, 10);
    waitCycles(300);
    checkAll("gap_abort", v0, c0, f0, 0, 0, 1);
    applyStimulus("f0000", 16'h0000);

    applyStimulus("f830B_again", 16'h830B);
    applyStimulus("cmd5_hold", 16'h00AA);

    v0 = n_valid; c0 = n_crc; f0 = n_ferr;
    dshot_in = 1'b1;
    waitCycles(4);
    dshot_in = 1'b0;
    waitCycles(40);
    checkAll("glitch", v0, c0, f0, 0, 0, 1);

    v0 = n_valid; c0 = n_crc; f0 = n_ferr;
    dshot_in = 1'b1;
    waitCycles(200);
    dshot_in = 1'b0;
    waitCycles(40);
    checkAll("stuck_high", v0, c0, f0, 0, 0, 1);

    sendBits(16'h830B, 8);
    doReset();
    v0 = n_valid; c0 = n_crc; f0 = n_ferr;
    waitCycles(300);
    checkAll("reset_mid", v0, c0, f0, 0, 0, 0);

    for (int k = 0; k < 15; k++) begin
      logic [10:0] thr;
      logic [15:0] w;
      if ($urandom_range(3) == 0) thr = 11'($urandom_range(47));
      else                        thr = 11'($urandom_range(2047));
      w = {thr, 1'($urandom_range(1)), 4'h0};
      w[3:0] = modelCrc(w);
      if (bad_streak < 3 && $urandom_range(9) < 3) begin
        w[3:0] = w[3:0] ^ 4'($urandom_range(15, 1));
        bad_streak++;
      end else begin
        bad_streak = 0;
      end
      applyStimulus("random", w);
    end

`ifdef DSHOT_FAILSAFE_EN
    applyStimulus("fs_arm", 16'h830B);
    waitCycles(15000);
    checkOutput("fs_before_timeout", 32'(failsafe), 32'd0);
    v0 = n_valid; c0 = n_crc; f0 = n_ferr;
    waitCycles(1000);
    exp_failsafe = 1'b1;
    exp_speed    = 8'd0;
    checkAll("fs_timeout", v0, c0, f0, 0, 0, 0);
    applyStimulus("fs_clear", 16'h830B);
`endif

    checkOutput("pulse_overlap", 32'(n_overlap), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
